// File: rtl/instruction_fetch_queue_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// Opcode constants, immediate extraction and the queue entry layout.
package instruction_fetch_queue_pkg;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef struct packed {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        redirected;
   } ifq_entry_t;

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_12(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: icache side, decode side and redirect inputs.
// master = the fetch queue, slave = icache/decode/ROB environment.
interface instruction_fetch_queue_if #(
   parameter int QUEUE_WIDTH = 3
);
   logic [31:0]          fetchOut;
   logic                 hit;
   logic [31:0]          icacheIn;
   logic                 clearIn;
   logic [31:0]          setPCVal;
   logic                 jumpFlag;
   logic [31:0]          jumpPC;
   logic                 insTake;
   logic                 insValid;
   logic [31:0]          insOut;
   logic [31:0]          insPCOut;
   logic                 insRedirected;
   logic [QUEUE_WIDTH:0] queueCount;
   logic                 queueFull;

   modport master (
      output fetchOut, insValid, insOut, insPCOut,
      output insRedirected, queueCount, queueFull,
      input  hit, icacheIn, clearIn, setPCVal,
      input  jumpFlag, jumpPC, insTake
   );

   modport slave (
      input  fetchOut, insValid, insOut, insPCOut,
      input  insRedirected, queueCount, queueFull,
      output hit, icacheIn, clearIn, setPCVal,
      output jumpFlag, jumpPC, insTake
   );
endinterface

// File: rtl/instruction_fetch_queue_storage.sv
// ifq_storage: generic 2^WIDTH-entry ring buffer of fetch entries.
// Push/pop/flush with occupancy count; push at full needs a pop.
module ifq_storage
   import instruction_fetch_queue_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  ifq_entry_t       din,
   output ifq_entry_t       dout,
   output logic [WIDTH:0]   count,
   output logic             full,
   output logic             empty,
   output logic             accepted
);
   localparam int DEPTH = 1 << WIDTH;

   ifq_entry_t       mem [DEPTH];
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tail;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (WIDTH+1)'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign accepted = en & ~flush & do_push;
   assign dout     = mem[head];

   // ring pointers, occupancy and entry storage
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (en) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (do_push) begin
               mem[tail] <= din;
               tail      <= tail + 1'b1;
            end
            if (do_pop) head <= head + 1'b1;
            case ({do_push, do_pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, buffers icache words.
// Optional JAL predecode redirect with macro IFQ_JAL_PREDECODE_EN.
module instruction_fetch_queue
   import instruction_fetch_queue_pkg::*;
#(
   parameter int          QUEUE_WIDTH = 3,
   parameter logic [31:0] RESET_PC    = 32'h0
) (
   input  logic                           clockIn,
   input  logic                           resetIn,
   input  logic                           readyIn,
   instruction_fetch_queue_if.master      bus
);
   logic [31:0] fetch_addr;
   logic [31:0] next_seq;
   logic        flush;
   logic        push;
   logic        pop;
   logic        accepted;
   logic        empty;
   logic        full;
   logic        redirected;
   ifq_entry_t  din;
   ifq_entry_t  dout;

   assign flush = bus.clearIn | bus.jumpFlag;
   assign push  = bus.hit & ~flush;
   assign pop   = bus.insTake & ~flush;

`ifdef IFQ_JAL_PREDECODE_EN
   // follow a fetched jal immediately instead of the next word
   always_comb begin
      redirected = 1'b0;
      next_seq   = fetch_addr + 32'd4;
      if (bus.icacheIn[6:0] == OP_JAL) begin
         redirected = 1'b1;
         next_seq   = fetch_addr + imm_j(bus.icacheIn);
      end
   end
`else
   assign redirected = 1'b0;
   assign next_seq   = fetch_addr + 32'd4;
`endif

   assign din = '{ins: bus.icacheIn, pc: fetch_addr, redirected: redirected};

   ifq_storage #(.WIDTH(QUEUE_WIDTH)) u_storage (
      .clk      (clockIn),
      .rst      (resetIn),
      .en       (readyIn),
      .flush    (flush),
      .push     (push),
      .pop      (pop),
      .din      (din),
      .dout     (dout),
      .count    (bus.queueCount),
      .full     (full),
      .empty    (empty),
      .accepted (accepted)
   );

   // fetch PC: clear beats jump beats sequential advance
   always_ff @(posedge clockIn) begin
      if (resetIn) begin
         fetch_addr <= RESET_PC;
      end else if (readyIn) begin
         if (bus.clearIn)       fetch_addr <= bus.setPCVal;
         else if (bus.jumpFlag) fetch_addr <= bus.jumpPC;
         else if (accepted)     fetch_addr <= next_seq;
      end
   end

   assign bus.fetchOut      = fetch_addr;
   assign bus.insValid      = ~empty;
   assign bus.insOut        = dout.ins;
   assign bus.insPCOut      = dout.pc;
   assign bus.insRedirected = dout.redirected;
   assign bus.queueFull     = full;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed self-checking bench for instruction_fetch_queue.
// Expected values are hand-computed per step (RESET_PC = 0x100).
module tb_instruction_fetch_queue;
   logic clk = 1'b0;
   logic rst;
   logic ready;
   int   checks   = 0;
   int   failures = 0;

   instruction_fetch_queue_if #(.QUEUE_WIDTH(3)) bus ();

   instruction_fetch_queue #(
      .QUEUE_WIDTH (3),
      .RESET_PC    (32'h100)
   ) dut (
      .clockIn (clk),
      .resetIn (rst),
      .readyIn (ready),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] w(input logic [31:0] a);
      return {a[19:0], 12'h013};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ready = 1'b1;
      bus.hit = 0; bus.icacheIn = 0; bus.clearIn = 0; bus.setPCVal = 0;
      bus.jumpFlag = 0; bus.jumpPC = 0; bus.insTake = 0;
      step(); step();
      check("rst_fetch", bus.fetchOut, 32'h100);
      check("rst_valid", 32'(bus.insValid), 0);
      check("rst_ins", bus.insOut, 0);
      check("rst_pc", bus.insPCOut, 0);
      check("rst_redir", 32'(bus.insRedirected), 0);
      check("rst_count", 32'(bus.queueCount), 0);
      check("rst_full", 32'(bus.queueFull), 0);
      rst = 1'b0;

      // three sequential hits
      bus.hit = 1; bus.icacheIn = w(32'h100);
      step();
      check("t1_fetch1", bus.fetchOut, 32'h104);
      check("t1_valid", 32'(bus.insValid), 1);
      bus.icacheIn = w(32'h104);
      step();
      check("t1_fetch2", bus.fetchOut, 32'h108);
      bus.icacheIn = w(32'h108);
      step();
      check("t1_count", 32'(bus.queueCount), 3);
      check("t1_pc", bus.insPCOut, 32'h100);
      check("t1_ins", bus.insOut, w(32'h100));
      check("t1_fetch3", bus.fetchOut, 32'h10C);

      // readyIn low freezes everything
      ready = 0; bus.hit = 1; bus.insTake = 1; bus.icacheIn = w(32'h10C);
      step(); step(); step();
      check("frz_count", 32'(bus.queueCount), 3);
      check("frz_fetch", bus.fetchOut, 32'h10C);
      check("frz_pc", bus.insPCOut, 32'h100);
      ready = 1; bus.hit = 0;
      step();
      check("pop_count", 32'(bus.queueCount), 2);
      check("pop_pc", bus.insPCOut, 32'h104);
      bus.insTake = 0;

      // fill to 5 then redirect
      bus.hit = 1;
      for (int i = 0; i < 3; i++) begin
         bus.icacheIn = w(32'h10C + 32'(4 * i));
         step();
      end
      check("j_count5", 32'(bus.queueCount), 5);
      check("j_fetchpre", bus.fetchOut, 32'h118);
      bus.jumpFlag = 1; bus.jumpPC = 32'h400; bus.insTake = 1;
      step();
      check("j_count", 32'(bus.queueCount), 0);
      check("j_valid", 32'(bus.insValid), 0);
      check("j_fetch", bus.fetchOut, 32'h400);
      bus.jumpFlag = 0; bus.insTake = 0; bus.icacheIn = w(32'h400);
      step();
      check("j_lat_valid", 32'(bus.insValid), 1);
      check("j_lat_pc", bus.insPCOut, 32'h400);
      check("j_lat_ins", bus.insOut, w(32'h400));
      check("j_lat_fetch", bus.fetchOut, 32'h404);

      // clear beats jump
      bus.clearIn = 1; bus.setPCVal = 32'h80;
      bus.jumpFlag = 1; bus.jumpPC = 32'h400;
      step();
      check("c_fetch", bus.fetchOut, 32'h80);
      check("c_count", 32'(bus.queueCount), 0);
      bus.jumpFlag = 0; bus.hit = 0; bus.setPCVal = 32'h0;
      step();
      check("c0_fetch", bus.fetchOut, 32'h0);
      bus.clearIn = 0;

      // fill past full
      bus.hit = 1;
      for (int i = 0; i < 10; i++) begin
         bus.icacheIn = w((i < 8) ? 32'(4 * i) : 32'h20);
         step();
         if (i == 7) begin
            check("f_full8", 32'(bus.queueFull), 1);
            check("f_count8", 32'(bus.queueCount), 8);
         end
      end
      check("f_full", 32'(bus.queueFull), 1);
      check("f_count", 32'(bus.queueCount), 8);
      check("f_fetch", bus.fetchOut, 32'h20);
      check("f_pc", bus.insPCOut, 32'h0);
      bus.insTake = 1; bus.icacheIn = w(32'h20);
      step();
      check("f_pp_count", 32'(bus.queueCount), 8);
      check("f_pp_fetch", bus.fetchOut, 32'h24);
      check("f_pp_pc", bus.insPCOut, 32'h4);
      bus.hit = 0;

      // drain across pointer wrap, then pop on empty
      for (int i = 0; i < 8; i++) begin
         check("d_pc", bus.insPCOut, 32'(4 * (i + 1)));
         check("d_ins", bus.insOut, w(32'(4 * (i + 1))));
         step();
      end
      check("d_count", 32'(bus.queueCount), 0);
      check("d_valid", 32'(bus.insValid), 0);
      step();
      check("d_empty_pop", 32'(bus.queueCount), 0);
      bus.insTake = 0;

      // jal x0,+16 at address 0
      bus.clearIn = 1; bus.setPCVal = 32'h0;
      step();
      bus.clearIn = 0; bus.hit = 1; bus.icacheIn = 32'h0100006F;
      step();
      bus.hit = 0;
      check("jal_ins", bus.insOut, 32'h0100006F);
      check("jal_pc", bus.insPCOut, 32'h0);
`ifdef IFQ_JAL_PREDECODE_EN
      check("jal_fetch", bus.fetchOut, 32'h10);
      check("jal_redir", 32'(bus.insRedirected), 1);
`else
      check("jal_fetch", bus.fetchOut, 32'h4);
      check("jal_redir", 32'(bus.insRedirected), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Decoupled instruction fetch stage placed between the icache and decode/issue. It replaces the single instruction register with a parametrised circular queue of {instruction, PC} entries, so fetch keeps running while decode stalls on full ROB/RS/LSB. It owns the fetch PC and honours decode-stage jump redirects and ROB mispredict clears.

Parameters:
QUEUE_WIDTH, 3, log2 of queue depth; DEPTH = 2^QUEUE_WIDTH entries.
RESET_PC, 32'h0, fetch address loaded on reset.

Ports:
clockIn  input  1  clock
resetIn  input  1  synchronous active-high reset
readyIn  input  1  global enable; when low, no state changes
fetchOut  output  32  icache fetch address
hit  input  1  icache has data for fetchOut this cycle
icacheIn  input  32  instruction word for fetchOut
clearIn  input  1  ROB mispredict flush
setPCVal  input  32  restart PC with clearIn
jumpFlag  input  1  decode redirect (jal/jalr/predicted-taken branch); implies head consumed
jumpPC  input  32  redirect target
insTake  input  1  decode consumes head entry this cycle
insValid  output  1  head entry valid
insOut  output  32  head instruction
insPCOut  output  32  head instruction PC
insRedirected  output  1  head already redirected by predecode (0 without macro)
queueCount  output  QUEUE_WIDTH+1  occupancy
queueFull  output  1  queueCount == DEPTH

Behaviour:
- Reset: fetchAddr=RESET_PC, headPtr=tailPtr=0, count=0; insValid=0, insOut=0, insPCOut=0, insRedirected=0, queueFull=0.
- All updates only when readyIn=1; readyIn=0 freezes state, and insTake/jumpFlag/hit are ignored.
- Priority per cycle: resetIn > clearIn > jumpFlag > normal push/pop.
- clearIn: empty queue, fetchAddr<=setPCVal; the same cycle's hit is discarded.
- jumpFlag: empty queue (head plus wrong-path entries), fetchAddr<=jumpPC; the same cycle's hit is discarded. insTake is don't-care.
- Push: when hit and (count<DEPTH or pop this cycle), write {icacheIn, fetchAddr} at tailPtr, tailPtr++, fetchAddr<=fetchAddr+4. With hit and the queue full without a pop, fetchAddr holds and the word is re-fetched later.
- Pop: when insTake and count!=0, headPtr++. insTake on an empty queue is ignored.
- Simultaneous push+pop: count is unchanged; legal at full and at empty+1.
- Pointers are QUEUE_WIDTH bits and wrap naturally. count is QUEUE_WIDTH+1 bits.
- Outputs insValid=(count!=0) and insOut/insPCOut=entry[headPtr] are combinational from registers, with no comb path from insTake.
- Latency: hit at cycle N into an empty queue gives insValid at N+1. Redirect at N gives fetchOut=target at N+1 and first valid target instruction at N+2 on hit.

Optional Feature:
IFQ_JAL_PREDECODE_EN.
- Defined: on push of a word with opcode 1101111, fetchAddr<=fetchAddr+immJ instead of +4, and the entry stores redirected=1, which drives insRedirected at head. Decode must not redirect again for it; if jumpFlag is still asserted it is honoured normally.
- Undefined: sequential fetch only, insRedirected tied 0, no predecode logic.

Decomposition:
- Shared package:
  - opcode constants (JAL=7'b1101111, JALR, BRANCH, etc.)
  - immJ/immB/imm12 extraction functions
  - IFQ entry struct {ins[31:0], pc[31:0], redirected}
- One sub-module: ifq_storage, a generic DEPTH-entry ring buffer with push/pop/flush, count and full/empty flags. The top module holds fetch-PC and redirect control.

Test Plan:
- Reset with RESET_PC=32'h100, hit=1 for 3 cycles, insTake=0 -> fetchOut 100,104,108; queueCount=3; insPCOut=32'h100.
- insTake=0, hit=1 for 10 cycles, DEPTH=8 -> queueFull=1 after 8 pushes; fetchOut holds 32'h20; a single insTake then admits word 0x20 with count staying 8.
- Queue holding 5 entries, jumpFlag=1 with jumpPC=32'h400 -> next cycle count=0, insValid=0, fetchOut=32'h400.
- clearIn=1 with setPCVal=32'h80 together with jumpFlag=1 with jumpPC=32'h400 -> fetchOut=32'h80; clear wins.
- readyIn=0 for 3 cycles with hit=1 and insTake=1 -> pointers, count and fetchOut unchanged.
- IFQ_JAL_PREDECODE_EN, jal x0,+16 (32'h0100006F) fetched at 32'h0 -> next fetchOut=32'h10; entry shows insRedirected=1. Without the macro -> fetchOut=32'h4 and insRedirected=0.
